// File: rtl/dmem_pkg.sv
// Shared types and funct3 decode for the byte-serial data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} dmem_state_t;
  typedef enum logic {GNT_CPU, GNT_LDR} grant_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Number of RAM bytes an access touches; 0 marks an illegal funct3.
  function automatic logic [2:0] f3_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      F3_W:        return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_load_extend.sv
// Sign/zero extension of an assembled little-endian load of n bytes.
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [2:0]  n_i,
  input  logic        unsigned_i,
  output logic [31:0] ext_o
);

  always_comb begin
    case (n_i)
      3'd1:    ext_o = {{24{raw_i[7] & ~unsigned_i}}, raw_i[7:0]};
      3'd2:    ext_o = {{16{raw_i[15] & ~unsigned_i}}, raw_i[15:0]};
      3'd4:    ext_o = raw_i;
      default: ext_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port arbiter and byte-serial sequencer in front of an 8-bit-wide data RAM.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [2:0]               cpu_funct3,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_ready,
  input  logic                     ldr_req,
  input  logic                     ldr_we,
  input  logic [ADDRESS_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0]    ldr_wdata,
  output logic [DATA_WIDTH-1:0]    ldr_rdata,
  output logic                     ldr_ready,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_we,
  output logic [7:0]               mem_wd,
  input  logic [7:0]               mem_rd
);

  dmem_state_t              state_q;
  grant_t                   gnt_q, last_grant_q;
  logic                     we_q, uns_q, last_q;
  logic [2:0]               n_q;
  logic [1:0]               cnt_q;
  logic [DATA_WIDTH-1:0]    wdata_q, raw_q, raw_d, ext;
  logic [DATA_WIDTH-1:0]    cpu_rdata_q, ldr_rdata_q;
  logic                     cpu_ready_q, ldr_ready_q, mem_we_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [7:0]               mem_wd_q;

  grant_t                   pick_d;
  logic                     any_req;
  logic                     sel_we;
  logic [2:0]               sel_f3, sel_n;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;

  // Round-robin pick among present requesters; the loader only issues words.
  always_comb begin
    any_req = cpu_req | ldr_req;
    if (cpu_req && (!ldr_req || last_grant_q == GNT_LDR)) pick_d = GNT_CPU;
    else                                                  pick_d = GNT_LDR;
    sel_f3    = (pick_d == GNT_CPU) ? cpu_funct3 : F3_W;
    sel_we    = (pick_d == GNT_CPU) ? cpu_we     : ldr_we;
    sel_addr  = (pick_d == GNT_CPU) ? cpu_addr   : ldr_addr;
    sel_wdata = (pick_d == GNT_CPU) ? cpu_wdata  : ldr_wdata;
    sel_n     = f3_bytes(sel_f3);
    raw_d     = raw_q;
    raw_d[{cnt_q, 3'b000} +: 8] = mem_rd;
  end

  load_extend u_ext (
    .raw_i      (raw_d),
    .n_i        (n_q),
    .unsigned_i (uns_q),
    .ext_o      (ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= GNT_CPU;
      last_grant_q <= GNT_LDR;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      last_q       <= 1'b0;
      n_q          <= '0;
      cnt_q        <= '0;
      wdata_q      <= '0;
      raw_q        <= '0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
      cpu_ready_q  <= 1'b0;
      ldr_ready_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q        <= pick_d;
            last_grant_q <= pick_d;
            we_q         <= sel_we;
            uns_q        <= sel_f3[2];
            n_q          <= sel_n;
            cnt_q        <= '0;
            last_q       <= (sel_n == 3'd1);
            wdata_q      <= sel_wdata;
            raw_q        <= '0;
            mem_addr_q   <= sel_addr;
            mem_wd_q     <= sel_wdata[7:0];
            if (sel_n == 3'd0) begin
              // Illegal size: complete immediately with zero data, no RAM traffic.
              state_q <= DONE;
              if (pick_d == GNT_CPU) begin
                cpu_ready_q <= 1'b1;
                cpu_rdata_q <= '0;
              end else begin
                ldr_ready_q <= 1'b1;
                ldr_rdata_q <= '0;
              end
            end else begin
              state_q  <= ACCESS;
              mem_we_q <= sel_we;
            end
          end
        end
        ACCESS: begin
          raw_q <= raw_d;
          if (last_q) begin
            state_q  <= DONE;
            mem_we_q <= 1'b0;
            if (gnt_q == GNT_CPU) begin
              cpu_ready_q <= 1'b1;
              cpu_rdata_q <= we_q ? '0 : ext;
            end else begin
              ldr_ready_q <= 1'b1;
              ldr_rdata_q <= we_q ? '0 : ext;
            end
          end else begin
            cnt_q      <= cnt_q + 2'd1;
            last_q     <= ({1'b0, cnt_q} + 3'd2 == n_q);
            mem_addr_q <= mem_addr_q + 1'b1;
            mem_wd_q   <= wdata_q[15:8];
            wdata_q    <= wdata_q >> 8;
          end
        end
        DONE: begin
          cpu_ready_q <= 1'b0;
          ldr_ready_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign ldr_rdata = ldr_rdata_q;
  assign ldr_ready = ldr_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wd    = mem_wd_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: byte RAM environment plus a transaction-level memory model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [2:0]  cpu_funct3 = 3'b010;
  logic [11:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [11:0] ldr_addr = '0;
  logic [31:0] ldr_wdata = '0;
  logic [31:0] ldr_rdata;
  logic        ldr_ready;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wd;
  logic [7:0]  mem_rd;

  logic [7:0]  ram [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ready(ldr_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Byte RAM: asynchronous read, write on the rising edge; preload port used only during reset.
  assign mem_rd = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wd;
    else if (pre_en) ram[pre_addr] <= pre_data;
  end

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [11:0] addr, input logic [2:0] f3, input bit is_ldr);
    int n;
    logic [31:0] v;
    n = is_ldr ? 4 : size_of(f3);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + 12'(i)]) << (8 * i));
    if (!is_ldr && !f3[2] && n > 0 && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [11:0] addr, input logic [2:0] f3, input bit is_ldr, input logic [31:0] wd);
    int n;
    n = is_ldr ? 4 : size_of(f3);
    for (int i = 0; i < n; i++) ref_mem[addr + 12'(i)] = 8'(wd >> (8 * i));
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_op(input bit is_ldr, input bit we, input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] wd, output int cyc, output bit got, output logic [31:0] rd,
                        output bit we_seen, output bit wrong_ready);
    @(negedge clk);
    if (is_ldr) begin
      ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = addr; cpu_wdata = wd;
    end
    cyc = 0; got = 1'b0; rd = '0; we_seen = 1'b0; wrong_ready = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_we) we_seen = 1'b1;
      if (is_ldr ? cpu_ready : ldr_ready) wrong_ready = 1'b1;
      if (is_ldr ? ldr_ready : cpu_ready) begin
        got = 1'b1;
        rd = is_ldr ? ldr_rdata : cpu_rdata;
      end
    end
    @(negedge clk);
    cpu_req = 1'b0; ldr_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int a = 0; a < 4096; a++) begin
      @(negedge clk);
      pre_en = 1'b1; pre_addr = 12'(a); pre_data = 8'($urandom);
      ref_mem[a] = pre_data;
    end
    @(negedge clk); pre_en = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (cpu_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_cpu_ready: got %b expected 0", cpu_ready); end
    n_vec++; if (ldr_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_ldr_ready: got %b expected 0", ldr_ready); end
    n_vec++; if (mem_we !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
    n_vec++; if (mem_addr !== 12'h000) begin n_miss++; $display("[TB] FAIL reset_mem_addr: got %h expected 000", mem_addr); end
    n_vec++; if (mem_wd !== 8'h00) begin n_miss++; $display("[TB] FAIL reset_mem_wd: got %h expected 00", mem_wd); end
    n_vec++; if (cpu_rdata !== 32'h0) begin n_miss++; $display("[TB] FAIL reset_cpu_rdata: got %h expected 0", cpu_rdata); end
    n_vec++; if (ldr_rdata !== 32'h0) begin n_miss++; $display("[TB] FAIL reset_ldr_rdata: got %h expected 0", ldr_rdata); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed;
    int cyc; bit got, wes, wr; logic [31:0] rd;
    run_op(1'b0, 1'b1, 3'b010, 12'h010, 32'hDEADBEEF, cyc, got, rd, wes, wr);
    model_store(12'h010, 3'b010, 1'b0, 32'hDEADBEEF);
    n_vec++; if (!got || cyc != 5) begin n_miss++; $display("[TB] FAIL sw_latency: got %0d cycles (done=%0d) expected 5", cyc, got); end
    n_vec++; if ({ram[12'h013], ram[12'h012], ram[12'h011], ram[12'h010]} !== 32'hDEADBEEF)
      begin n_miss++; $display("[TB] FAIL sw_bytes: got %h%h%h%h expected DEADBEEF", ram[12'h013], ram[12'h012], ram[12'h011], ram[12'h010]); end
    run_op(1'b0, 1'b0, 3'b010, 12'h010, 32'h0, cyc, got, rd, wes, wr);
    n_vec++; if (!got || cyc != 5) begin n_miss++; $display("[TB] FAIL lw_latency: got %0d expected 5", cyc); end
    n_vec++; if (rd !== 32'hDEADBEEF) begin n_miss++; $display("[TB] FAIL lw_data: got %h expected DEADBEEF", rd); end
    run_op(1'b0, 1'b0, 3'b000, 12'h013, 32'h0, cyc, got, rd, wes, wr);
    n_vec++; if (!got || cyc != 2) begin n_miss++; $display("[TB] FAIL lb_latency: got %0d expected 2", cyc); end
    n_vec++; if (rd !== 32'hFFFFFFDE) begin n_miss++; $display("[TB] FAIL lb_data: got %h expected FFFFFFDE", rd); end
    run_op(1'b0, 1'b0, 3'b100, 12'h013, 32'h0, cyc, got, rd, wes, wr);
    n_vec++; if (rd !== 32'h000000DE) begin n_miss++; $display("[TB] FAIL lbu_data: got %h expected 000000DE", rd); end
    run_op(1'b0, 1'b0, 3'b001, 12'h012, 32'h0, cyc, got, rd, wes, wr);
    n_vec++; if (!got || cyc != 3) begin n_miss++; $display("[TB] FAIL lh_latency: got %0d expected 3", cyc); end
    n_vec++; if (rd !== 32'hFFFFDEAD) begin n_miss++; $display("[TB] FAIL lh_data: got %h expected FFFFDEAD", rd); end
  endtask

  task automatic test_wrap;
    int cyc; bit got, wes, wr; logic [31:0] rd;
    run_op(1'b0, 1'b1, 3'b010, 12'hFFE, 32'h11223344, cyc, got, rd, wes, wr);
    model_store(12'hFFE, 3'b010, 1'b0, 32'h11223344);
    n_vec++; if ({ram[12'h001], ram[12'h000], ram[12'hFFF], ram[12'hFFE]} !== 32'h11223344)
      begin n_miss++; $display("[TB] FAIL wrap_bytes: got %h %h %h %h expected 11 22 33 44", ram[12'h001], ram[12'h000], ram[12'hFFF], ram[12'hFFE]); end
    run_op(1'b1, 1'b0, 3'b010, 12'hFFE, 32'h0, cyc, got, rd, wes, wr);
    n_vec++; if (!got || cyc != 5 || wr) begin n_miss++; $display("[TB] FAIL wrap_ldr_latency: got %0d (cpu_ready seen=%0d) expected 5", cyc, wr); end
    n_vec++; if (rd !== 32'h11223344) begin n_miss++; $display("[TB] FAIL wrap_ldr_data: got %h expected 11223344", rd); end
  endtask

  task automatic test_illegal;
    int cyc; bit got, wes, wr; logic [31:0] rd;
    run_op(1'b0, 1'b1, 3'b011, 12'h020, 32'hCAFEF00D, cyc, got, rd, wes, wr);
    n_vec++; if (!got || cyc != 1) begin n_miss++; $display("[TB] FAIL illegal_latency: got %0d expected 1", cyc); end
    n_vec++; if (rd !== 32'h0) begin n_miss++; $display("[TB] FAIL illegal_rdata: got %h expected 0", rd); end
    n_vec++; if (wes) begin n_miss++; $display("[TB] FAIL illegal_mem_we: got 1 expected 0"); end
  endtask

  task automatic test_back_to_back;
    bit who [3];
    int at [3];
    int pulses, cyc;
    bit prev;
    logic [31:0] rdv;
    do_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 12'h010;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 12'hFFE;
    pulses = 0; cyc = 0; prev = 1'b0;
    while (pulses < 3 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cpu_ready || ldr_ready) begin
        n_vec++; if (prev || (cpu_ready && ldr_ready)) begin n_miss++; $display("[TB] FAIL rr_pulse_width: ready high at cycle %0d after previous ready", cyc); end
        who[pulses] = ldr_ready; at[pulses] = cyc;
        rdv = ldr_ready ? ldr_rdata : cpu_rdata;
        n_vec++; if (rdv !== model_load(ldr_ready ? 12'hFFE : 12'h010, 3'b010, ldr_ready))
          begin n_miss++; $display("[TB] FAIL rr_data: pulse %0d got %h expected %h", pulses, rdv, model_load(ldr_ready ? 12'hFFE : 12'h010, 3'b010, ldr_ready)); end
        pulses++;
      end
      prev = cpu_ready | ldr_ready;
    end
    @(negedge clk); cpu_req = 1'b0; ldr_req = 1'b0;
    n_vec++; if (pulses != 3) begin n_miss++; $display("[TB] FAIL rr_timeout: got %0d pulses expected 3", pulses); end
    else begin
      n_vec++; if (who[0] || !who[1] || who[2]) begin n_miss++; $display("[TB] FAIL rr_order: got %0d%0d%0d (1=ldr) expected 010", who[0], who[1], who[2]); end
      n_vec++; if (at[0] != 5 || at[1] != 11 || at[2] != 17) begin n_miss++; $display("[TB] FAIL rr_spacing: got %0d,%0d,%0d expected 5,11,17", at[0], at[1], at[2]); end
    end
  endtask

  task automatic test_random;
    int cyc, exp_n; bit got, wes, wr, is_ldr, we; logic [31:0] rd, wd, exp_rd; logic [2:0] f3; logic [11:0] addr;
    for (int k = 0; k < 60; k++) begin
      is_ldr = ($urandom_range(0, 3) == 0);
      we     = $urandom_range(0, 1) == 1;
      f3     = is_ldr ? 3'b010 : 3'($urandom_range(0, 7));
      addr   = ($urandom_range(0, 1) == 1) ? 12'hFFC + 12'($urandom_range(0, 3)) : 12'($urandom);
      wd     = $urandom;
      exp_n  = is_ldr ? 4 : size_of(f3);
      exp_rd = (exp_n == 0) ? 32'h0 : model_load(addr, f3, is_ldr);
      run_op(is_ldr, we, f3, addr, wd, cyc, got, rd, wes, wr);
      n_vec++; if (!got || cyc != exp_n + 1 || wr)
        begin n_miss++; $display("[TB] FAIL rand_latency op %0d: got %0d cycles (done=%0d, other ready=%0d) expected %0d", k, cyc, got, wr, exp_n + 1); end
      if (!we || exp_n == 0) begin
        n_vec++; if (rd !== exp_rd) begin n_miss++; $display("[TB] FAIL rand_data op %0d addr %h f3 %b: got %h expected %h", k, addr, f3, rd, exp_rd); end
      end
      n_vec++; if (wes !== (we && exp_n > 0)) begin n_miss++; $display("[TB] FAIL rand_mem_we op %0d: got %0d expected %0d", k, wes, we && exp_n > 0); end
      if (we) model_store(addr, f3, is_ldr, wd);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] old2, old3;
    bit rdy;
    old2 = ref_mem[12'h102]; old3 = ref_mem[12'h103];
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_funct3 = 3'b010; cpu_addr = 12'h100; cpu_wdata = 32'hAABBCCDD;
    rdy = 1'b0;
    @(posedge clk); #1; rdy = rdy | cpu_ready;
    @(posedge clk); #1; rdy = rdy | cpu_ready;
    @(negedge clk); rst_n = 1'b0; cpu_req = 1'b0;
    @(posedge clk); #1;
    n_vec++; if ({cpu_ready, ldr_ready, mem_we} !== 3'b000 || mem_addr !== 12'h0 || mem_wd !== 8'h0 || cpu_rdata !== 32'h0)
      begin n_miss++; $display("[TB] FAIL abort_outputs: got ready=%b ldr=%b we=%b addr=%h wd=%h rdata=%h expected all 0", cpu_ready, ldr_ready, mem_we, mem_addr, mem_wd, cpu_rdata); end
    @(negedge clk); rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; rdy = rdy | cpu_ready; end
    n_vec++; if (rdy) begin n_miss++; $display("[TB] FAIL abort_ready: got pulse expected none"); end
    n_vec++; if ({ram[12'h103], ram[12'h102], ram[12'h101], ram[12'h100]} !== {old3, old2, 16'hCCDD})
      begin n_miss++; $display("[TB] FAIL abort_bytes: got %h%h%h%h expected %h%hCCDD", ram[12'h103], ram[12'h102], ram[12'h101], ram[12'h100], old3, old2); end
    ref_mem[12'h100] = 8'hDD; ref_mem[12'h101] = 8'hCC;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
